// File: rtl/frame_luma_stat_if.sv
// Pixel-side bundle for the frame luminance statistics stage: DE/VS/gray in, per-frame results out.
// Latency: n/a (wiring only).
// Backpressure: none; the pixel stream is never stalled.
interface frame_luma_stat_if;
    logic        de_i;
    logic        vs_i;
    logic [7:0]  gray_i;
    logic [7:0]  mean_o;
    logic        mean_valid_o;
    logic        invert_o;
    logic [15:0] frame_cnt_o;
    logic        err_o;

    modport master (
        output de_i, vs_i, gray_i,
        input  mean_o, mean_valid_o, invert_o, frame_cnt_o, err_o
    );

    modport slave (
        input  de_i, vs_i, gray_i,
        output mean_o, mean_valid_o, invert_o, frame_cnt_o, err_o
    );
endinterface

// File: rtl/frame_luma_stat.sv
// Per-frame luminance mean (restoring divider in blanking) and dark/bright invert decision.
// Latency: frame boundary on edge N -> mean/invert/frame count and mean_valid_o pulse on edge N+10.
// Backpressure: none; accumulation never stalls. Optional FRAME_LUMA_HYST_EN adds TH_LO hysteresis.
module frame_luma_stat #(
    parameter int unsigned CNT_W  = 22,
    parameter int unsigned TH_HI  = 144,
    parameter int unsigned TH_LO  = 112,
    parameter bit          VS_POL = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    frame_luma_stat_if.slave  lb
);

    localparam int unsigned      SUM_W   = CNT_W + 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [7:0]       HI      = 8'(TH_HI);
`ifdef FRAME_LUMA_HYST_EN
    localparam logic [7:0]       LO      = 8'(TH_LO);
`endif

    // Thresholds must leave a gap, otherwise hysteresis is meaningless.
    generate
        if (TH_LO >= TH_HI) begin : g_bad_thresh
            $error("frame_luma_stat: TH_LO must be below TH_HI");
        end
    endgenerate

    typedef enum logic [1:0] {ST_ARM, ST_ACC, ST_DIV, ST_DONE} state_t;

    state_t             state_q, state_d;
    logic               vs_act, vs_act_q, bnd;
    logic               div_load, div_step, publish, abort;
    logic               sat_hit, zero_div, ge;
    logic [SUM_W-1:0]   acc_sum_q, rem_q, dsh;
    logic [CNT_W-1:0]   acc_cnt_q, dcnt_q;
    logic [7:0]         quo_q;
    logic [3:0]         it_q;

    assign vs_act   = (lb.vs_i == VS_POL);
    assign bnd      = vs_act && !vs_act_q;
    // A pixel arriving with the counter already full is dropped and flagged.
    assign sat_hit  = lb.de_i && !bnd && (acc_cnt_q == CNT_MAX);
    assign dsh      = {8'd0, dcnt_q} << (3'd7 - it_q[2:0]);
    assign ge       = (rem_q >= dsh);
    assign zero_div = (dcnt_q == '0);

    // Previous VS level; reset as "active" so a VS held through reset is not a boundary.
    always_ff @(posedge clk_i) begin
        if (rst_i) vs_act_q <= 1'b1;
        else       vs_act_q <= vs_act;
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_ARM;
        else       state_q <= state_d;
    end

    // FSM next state: a boundary in DIV restarts the division with the new frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARM:  if (bnd) state_d = ST_ACC;
            ST_ACC:  if (bnd) state_d = ST_DIV;
            ST_DIV: begin
                if (bnd)                 state_d = ST_DIV;
                else if (it_q == 4'd8)   state_d = ST_DONE;
            end
            ST_DONE: state_d = bnd ? ST_DIV : ST_ACC;
            default: state_d = ST_ARM;
        endcase
    end

    // FSM outputs: divider load/step, result publish, overrun abort.
    always_comb begin
        div_load = 1'b0;
        div_step = 1'b0;
        publish  = 1'b0;
        abort    = 1'b0;
        case (state_q)
            ST_ACC:  div_load = bnd;
            ST_DIV: begin
                div_load = bnd;
                abort    = bnd;
                div_step = !bnd && (it_q != 4'd8);
            end
            ST_DONE: begin
                div_load = bnd;
                publish  = 1'b1;
            end
            default: ;
        endcase
    end

    // Accumulators: restart at each boundary (that edge's pixel opens the new frame), freeze on saturation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_sum_q <= '0;
            acc_cnt_q <= '0;
        end else if (bnd) begin
            acc_sum_q <= lb.de_i ? {{CNT_W{1'b0}}, lb.gray_i} : '0;
            acc_cnt_q <= {{(CNT_W-1){1'b0}}, lb.de_i};
        end else if (lb.de_i && !sat_hit) begin
            acc_sum_q <= acc_sum_q + {{CNT_W{1'b0}}, lb.gray_i};
            acc_cnt_q <= acc_cnt_q + 1'b1;
        end
    end

    // Restoring divider: one quotient bit per cycle, MSB first, trial subtract of cnt<<k.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q  <= '0;
            dcnt_q <= '0;
            quo_q  <= '0;
            it_q   <= '0;
        end else if (div_load) begin
            rem_q  <= acc_sum_q;
            dcnt_q <= acc_cnt_q;
            quo_q  <= '0;
            it_q   <= '0;
        end else if (div_step) begin
            if (ge) rem_q <= rem_q - dsh;
            quo_q <= {quo_q[6:0], ge};
            it_q  <= it_q + 4'd1;
        end
    end

    // Result registers; an empty frame reports mean 0 and keeps the previous invert decision.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lb.mean_o       <= '0;
            lb.mean_valid_o <= 1'b0;
            lb.invert_o     <= 1'b0;
            lb.frame_cnt_o  <= '0;
            lb.err_o        <= 1'b0;
        end else begin
            lb.mean_valid_o <= publish;
            if (sat_hit || abort) lb.err_o <= 1'b1;
            if (publish) begin
                lb.frame_cnt_o <= lb.frame_cnt_o + 16'd1;
                lb.mean_o      <= zero_div ? 8'd0 : quo_q;
                if (!zero_div) begin
`ifdef FRAME_LUMA_HYST_EN
                    if (quo_q >= HI)      lb.invert_o <= 1'b1;
                    else if (quo_q <= LO) lb.invert_o <= 1'b0;
`else
                    lb.invert_o <= (quo_q >= HI);
`endif
                end
            end
        end
    end

endmodule
